rgb_pwm_gen: RTL and testbench
==============================

// Module: rgb_pwm_gen
// PURPOSE
//   PWM source for the on-chip RGB LED driver. Accepts one {r,g,b} intensity word per
//   valid/ready handshake and produces three active-high PWM enables, which feed the
//   driver's RGB0PWM/RGB1PWM/RGB2PWM inputs. New intensities apply only at a PWM period
//   boundary, so the LED never shows a glitched partial period.
// PARAMETERS
//   PWM_BITS   8   duty resolution; one period = 2**PWM_BITS-1 ticks
//   PRESCALE   47  clocks per tick minus 1 (tick every PRESCALE+1 clk)
// PORTS
//   clk           in   1             system clock
//   rst           in   1             asynchronous, active-high reset
//   cfg_valid     in   1             cfg_rgb holds a new intensity word
//   cfg_ready     out  1             pending slot empty; word accepted when valid&&ready
//   cfg_rgb       in   3*PWM_BITS    {r,g,b}; r = MSB field
//   enable        in   1             0 forces all PWM outputs low
//   pwm_r/g/b     out  1 each        active-high PWM enables (registered)
//   period_start  out  1             1-clk pulse on each period wrap (registered)
// BEHAVIOUR
//   Reset: pwm_r/g/b=0, period_start=0, prescaler=0, pwm_cnt=0, active duties=0,
//     pending slot empty -> cfg_ready=1. Reset mid-period aborts the period immediately.
//   Prescaler counts 0..PRESCALE. tick is asserted when it equals PRESCALE. PRESCALE=0 ticks every clk.
//   On each tick, pwm_cnt advances 0..MAX-1 (MAX=2**PWM_BITS-1), then wraps to 0.
//     The wrap is the boundary event.
//   Output: pwm_x(t+1) = enable(t) && (pwm_cnt(t) < duty_x(t)).
//     duty 0 -> always low; duty MAX -> always high; duty d -> high d ticks of MAX.
//   period_start(t+1) = boundary(t). It keeps pulsing while enable=0 (counters free-run).
//   Handshake: cfg_ready = ~pending_valid, driven combinationally from a register.
//     On valid&&ready, cfg_rgb is captured into pending and pending_valid is set.
//     cfg_valid held while ready=0 -> the word is held off; no drop, no overwrite.
//     At the boundary with pending_valid=1, pending is applied to the target duties.
//     pending_valid clears in that same clock.
//   Accept and boundary in the same clk (pending empty): the word goes to pending and
//     applies at the NEXT boundary. There is no bypass.
//   Applied duties change only at a boundary, never mid-period.
// CONFIGURATION
//   RGB_PWM_FADE_EN defined:
//     At each boundary, each duty_x steps 1 LSB toward target_x.
//     Stepping stops when duty_x equals target_x. A new target redirects the ramp from the current duty.
//   RGB_PWM_FADE_EN undefined:
//     duty_x = target_x immediately at the applying boundary.
//     No ramp logic is synthesised.
// STRUCTURE
//   Shared package rgb_pkg:
//     channel index constants CH_R=2, CH_G=1, CH_B=0;
//     field-slice helper for cfg_rgb;
//     default PWM_BITS;
//     localparam PWM_MAX.
//   Top holds the prescaler, pwm_cnt, boundary/period_start, and the pending slot + handshake.
//   Sub-module rgb_pwm_channel, instantiated 3x:
//     target/duty registers;
//     optional fade stepper;
//     compare and registered output.
// TESTING  (bench: PWM_BITS=4 -> MAX=15, PRESCALE=0 unless noted)
//   1 Reset: assert rst mid-period with duties nonzero -> pwm_r/g/b=0, period_start=0 the
//     same clk, cfg_ready=1. Release -> first period_start exactly 15 clks later.
//   2 Write {r=0,g=15,b=5} (e.g. 12'h0F5) -> from the next boundary:
//       r low all 15 clks; g high all 15 clks; b high exactly 5 consecutive clks per period.
//   3 Two back-to-back writes A then B -> A accepted, cfg_ready=0 until the boundary,
//     B accepted the clk after. A is shown for one full period, then B.
//   4 Drop enable mid-period -> all outputs 0 from the next clk.
//     period_start spacing stays 15. Re-enable -> duty pattern resumes with its phase preserved.
//   5 PRESCALE=2 -> period_start pulses every 45 clks. b=5 gives 15 high clks per period.
//   6 RGB_PWM_FADE_EN defined, r 0->3 -> r high-tick counts are 1,2,3,3 in successive periods.
//     Then write r=1 -> 2,1,1.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED PWM source (rgb_pwm_gen).
// Optional build macro used by this block: RGB_PWM_FADE_EN (per-boundary fade ramp).
package rgb_pkg;

  localparam int unsigned PWM_BITS_DEF  = 8;
  localparam int unsigned PWM_MAX       = (1 << PWM_BITS_DEF) - 1;
  localparam int unsigned NUM_CH        = 3;
  localparam int unsigned CH_R          = 2;
  localparam int unsigned CH_G          = 1;
  localparam int unsigned CH_B          = 0;
  localparam int unsigned RGB_FIELD_MAX = 16;

  // Extract the bits-wide field for channel ch from a zero-extended {r,g,b} word.
  function automatic logic [RGB_FIELD_MAX-1:0] rgb_field(
    input logic [3*RGB_FIELD_MAX-1:0] word,
    input int unsigned                bits,
    input int unsigned                ch
  );
    logic [3*RGB_FIELD_MAX-1:0] sh;
    sh = word >> (ch * bits);
    return sh[RGB_FIELD_MAX-1:0] & ((RGB_FIELD_MAX'(1) << bits) - RGB_FIELD_MAX'(1));
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: target/duty registers, optional fade stepper, compare and output flop.
// With RGB_PWM_FADE_EN defined the duty ramps 1 LSB per boundary toward the target.
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boundary,
  input  logic                load,
  input  logic [PWM_BITS-1:0] load_val,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

`ifdef RGB_PWM_FADE_EN
  logic [PWM_BITS-1:0] target_q, target_d;

  // New target latches on load; duty steps toward the (possibly new) target each boundary.
  always_comb begin
    target_d = target_q;
    duty_d   = duty_q;
    if (load) target_d = load_val;
    if (boundary) begin
      if (duty_q < target_d)      duty_d = duty_q + PWM_BITS'(1);
      else if (duty_q > target_d) duty_d = duty_q - PWM_BITS'(1);
    end
  end

  // Target register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) target_q <= '0;
    else     target_q <= target_d;
  end
`else
  // Target is applied straight to the duty at the boundary that loads it.
  always_comb begin
    duty_d = duty_q;
    if (boundary && load) duty_d = load_val;
  end
`endif

  // Compare against the shared period counter; enable gates the output.
  always_comb begin
    pwm_d = enable && (pwm_cnt < duty_q);
  end

  // Duty and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// PWM source for the RGB LED driver: prescaler, period counter, boundary pulse and a
// one-deep pending slot for {r,g,b} intensity words; three rgb_pwm_channel instances.
// Optional build macro: RGB_PWM_FADE_EN (duty ramps toward the target at each boundary).
module rgb_pwm_gen
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned PRESCALE = 47
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3*PWM_BITS-1:0] cfg_rgb,
  input  logic                  enable,
  output logic                  pwm_r,
  output logic                  pwm_g,
  output logic                  pwm_b,
  output logic                  period_start
);

  localparam int unsigned PS_W    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int unsigned CNT_MAX = (1 << PWM_BITS) - 1;

  logic [PS_W-1:0]       prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  period_start_q, period_start_d;
  logic [3*PWM_BITS-1:0] pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  tick_c, wrap_c, accept_c, apply_c;
  logic [3*RGB_FIELD_MAX-1:0] pend_ext_c;
  logic [PWM_BITS-1:0]   load_val_c [NUM_CH];
  logic [NUM_CH-1:0]     pwm_ch;

  // Tick, period wrap and handshake qualifiers.
  always_comb begin
    tick_c   = (prescaler_q == PS_W'(PRESCALE));
    wrap_c   = tick_c && (pwm_cnt_q == PWM_BITS'(CNT_MAX - 1));
    accept_c = cfg_valid && !pend_valid_q;
    apply_c  = wrap_c && pend_valid_q;
  end

  // Next-state for counters, boundary pulse and pending slot.
  always_comb begin
    prescaler_d    = tick_c ? '0 : prescaler_q + PS_W'(1);
    pwm_cnt_d      = pwm_cnt_q;
    if (tick_c) pwm_cnt_d = wrap_c ? '0 : pwm_cnt_q + PWM_BITS'(1);
    period_start_d = wrap_c;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    if (apply_c) pend_valid_d = 1'b0;
    if (accept_c) begin
      pend_d       = cfg_rgb;
      pend_valid_d = 1'b1;
    end
  end

  // State registers; reset aborts the current period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
    end
  end

  assign pend_ext_c = (3*RGB_FIELD_MAX)'(pend_q);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load_val_c[c] = PWM_BITS'(rgb_field(pend_ext_c, PWM_BITS, c));

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .boundary (wrap_c),
      .load     (apply_c),
      .load_val (load_val_c[c]),
      .enable   (enable),
      .pwm_cnt  (pwm_cnt_q),
      .pwm      (pwm_ch[c])
    );
  end

  assign cfg_ready    = ~pend_valid_q;
  assign period_start = period_start_q;
  assign pwm_r        = pwm_ch[CH_R];
  assign pwm_g        = pwm_ch[CH_G];
  assign pwm_b        = pwm_ch[CH_B];

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Bench for rgb_pwm_gen (PWM_BITS=4). Accepted words go into a scoreboard queue; a
// monitor applies them at modelled period boundaries and checks per-period high counts.
module tb_rgb_pwm_gen;

  localparam int unsigned W      = 4;
  localparam int unsigned MAXV   = 15;
  localparam int          PERIOD = 15;

  typedef struct {
    int         e;
    logic [11:0] w;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, enable;
  logic [11:0] cfg_rgb;
  logic        pwm_r, pwm_g, pwm_b, period_start;

  logic        rst2, cfg_valid2, cfg_ready2;
  logic [11:0] cfg_rgb2;
  logic        pwm_r2, pwm_g2, pwm_b2, period_start2;

  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   rel_base = 0;
  acc_t acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  rgb_pwm_gen #(.PWM_BITS(W), .PRESCALE(0)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rgb(cfg_rgb),
    .enable(enable), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .period_start(period_start)
  );

  rgb_pwm_gen #(.PWM_BITS(W), .PRESCALE(2)) dut_ps (
    .clk(clk), .rst(rst2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2), .cfg_rgb(cfg_rgb2),
    .enable(1'b1), .pwm_r(pwm_r2), .pwm_g(pwm_g2), .pwm_b(pwm_b2), .period_start(period_start2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!cfg_ready) fail_now("wait_ready");
  endtask

  // Hold valid until ready; record the edge at which the word is taken.
  task automatic write_word(input logic [11:0] w, output int acc_e);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_rgb   = w;
    while (!cfg_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!cfg_ready) begin
      fail_now("handshake");
      acc_e     = -1;
      cfg_valid = 1'b0;
      return;
    end
    acc_e = edge_cnt + 1;
    acc_q.push_back('{acc_e, w});
    step(1);
    cfg_valid = 1'b0;
  endtask

  // Reference model + checker for the PRESCALE=0 instance.
  int    exp_duty [3];
  int    tgt      [3];
  int    hi_cnt   [3];
  bit    seen_low [3];
  bit    gap_err  [3];
  bit    win_valid, win_dirty;
  string chn [3] = '{"b", "g", "r"};

  always @(negedge clk) begin
    logic [2:0] pw;
    int         n;
    bit         bnd;
    acc_t       a;
    pw = {pwm_r, pwm_g, pwm_b};
    if (rst) begin
      rel_base  = edge_cnt;
      win_valid = 0;
      win_dirty = 0;
      acc_q.delete();
      for (int c = 0; c < 3; c++) begin
        exp_duty[c] = 0; tgt[c] = 0; hi_cnt[c] = 0; seen_low[c] = 0; gap_err[c] = 0;
      end
      chk("rst_pwm", 32'(pw), 0);
      chk("rst_period_start", 32'(period_start), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
    end else begin
      n   = edge_cnt - rel_base;
      bnd = (n > 0) && (n % PERIOD == 0);
      chk("period_start", 32'(period_start), 32'(bnd));
      if (!enable) begin
        chk("pwm_disabled", 32'(pw), 0);
        win_dirty = 1;
      end
      for (int c = 0; c < 3; c++) begin
        if (pw[c]) begin
          if (seen_low[c]) gap_err[c] = 1;
          hi_cnt[c]++;
        end else begin
          seen_low[c] = 1;
        end
      end
      if (bnd) begin
        if (win_valid && !win_dirty) begin
          for (int c = 0; c < 3; c++) begin
            chk({"high_ticks_", chn[c]}, 32'(hi_cnt[c]), 32'(exp_duty[c]));
            chk({"contiguous_", chn[c]}, 32'(gap_err[c]), 0);
          end
        end
        if (acc_q.size() > 0 && acc_q[0].e < edge_cnt) begin
          a = acc_q.pop_front();
          for (int c = 0; c < 3; c++) tgt[c] = int'((a.w >> (4 * c)) & 12'hF);
`ifndef RGB_PWM_FADE_EN
          for (int c = 0; c < 3; c++) exp_duty[c] = tgt[c];
`endif
        end
`ifdef RGB_PWM_FADE_EN
        for (int c = 0; c < 3; c++) begin
          if (exp_duty[c] < tgt[c])      exp_duty[c]++;
          else if (exp_duty[c] > tgt[c]) exp_duty[c]--;
        end
`endif
        for (int c = 0; c < 3; c++) begin
          hi_cnt[c] = 0; seen_low[c] = 0; gap_err[c] = 0;
        end
        win_valid = 1;
        win_dirty = 0;
      end
    end
  end

  // Checker for the PRESCALE=2 instance, loaded once with b=5.
  int last_ps2 = 0;
  int k2 = 0;
  int acc2 [3];
  always @(negedge clk) begin
    if (rst2) begin
      last_ps2 = edge_cnt;
      k2 = 0;
      for (int c = 0; c < 3; c++) acc2[c] = 0;
    end else begin
      acc2[0] += int'(pwm_b2);
      acc2[1] += int'(pwm_g2);
      acc2[2] += int'(pwm_r2);
      if (period_start2) begin
        k2++;
        chk("ps2_spacing", 32'(edge_cnt - last_ps2), 45);
        last_ps2 = edge_cnt;
`ifdef RGB_PWM_FADE_EN
        if (k2 >= 6) begin
`else
        if (k2 >= 2) begin
`endif
          chk("ps2_high_b", 32'(acc2[0]), 15);
          chk("ps2_high_g", 32'(acc2[1]), 0);
          chk("ps2_high_r", 32'(acc2[2]), 0);
        end
        for (int c = 0; c < 3; c++) acc2[c] = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e, ea, eb;
    rst = 1'b1; cfg_valid = 1'b0; cfg_rgb = '0; enable = 1'b1;
    rst2 = 1'b1; cfg_valid2 = 1'b0; cfg_rgb2 = '0;
    step(3);
    rst = 1'b0;
    rst2 = 1'b0;
    cfg_valid2 = 1'b1;
    cfg_rgb2   = 12'h005;
    step(1);
    cfg_valid2 = 1'b0;

    // r=0, g=15, b=5
    write_word(12'h0F5, e);
    step(4 * PERIOD);

    // back-to-back A then B
    wait_ready();
    write_word(12'hA3C, ea);
    chk("ready_low_after_accept", 32'(cfg_ready), 0);
    write_word(12'h5C7, eb);
    chk("b_accept_after_boundary", 32'((eb - 1 - rel_base) % PERIOD), 0);
    chk("b_stalled", 32'(eb > ea + 1), 1);
    step(4 * PERIOD);

    // enable drop mid-period, then resume
    step(7);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(3 * PERIOD);

    // r ramp 0 -> 3 then down to 1
    wait_ready();
    write_word(12'h000, e);
    step(3 * PERIOD);
    write_word(12'h300, e);
    step(5 * PERIOD);
    write_word(12'h100, e);
    step(4 * PERIOD);

    // reset mid-period with nonzero duties and a full pending slot
    write_word(12'hFFF, e);
    step(2 * PERIOD + 7);
    write_word(12'h123, e);
    rst = 1'b1;
    #1;
    chk("async_rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 0);
    chk("async_rst_period_start", 32'(period_start), 0);
    chk("async_rst_ready", 32'(cfg_ready), 1);
    step(2);
    rst = 1'b0;
    step(2 * PERIOD);

    // randomized words, gaps and enable drops
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 40));
      enable = ($urandom_range(0, 4) != 0);
      write_word(12'($urandom), e);
    end
    enable = 1'b1;
    step(8 * PERIOD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
